// File: rtl/id_exe_stage_if.sv
// ID/EX stage bus: decode inputs, forwarding sources and the registered EX-side outputs.
// The slave modport is the stage itself; the master modport is whatever drives decode.
interface id_exe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rt;
  logic              id_regrt;
  logic              id_wreg;
  logic              id_m2reg;
  logic              id_wmem;
  logic              id_aluimm;
  logic [ALUC_W-1:0] id_aluc;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic [DATA_W-1:0] ex_alu;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic [REG_AW-1:0] mem_dest;
  logic [DATA_W-1:0] mem_alu;
  logic [DATA_W-1:0] mem_dout;
  logic              flush;
  logic              stall;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic              ex_aluimm;
  logic [ALUC_W-1:0] ex_aluc;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_dest;
  logic [31:0]       stall_cnt;

  modport slave (
    input  id_rs, id_rt, id_rd, id_use_rt, id_regrt, id_wreg, id_m2reg, id_wmem,
           id_aluimm, id_aluc, id_imm, qa, qb, ex_alu,
           mem_wreg, mem_m2reg, mem_dest, mem_alu, mem_dout, flush,
    output stall, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc,
           ex_a, ex_b, ex_imm, ex_dest, stall_cnt
  );

  modport master (
    output id_rs, id_rt, id_rd, id_use_rt, id_regrt, id_wreg, id_m2reg, id_wmem,
           id_aluimm, id_aluc, id_imm, qa, qb, ex_alu,
           mem_wreg, mem_m2reg, mem_dest, mem_alu, mem_dout, flush,
    input  stall, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc,
           ex_a, ex_b, ex_imm, ex_dest, stall_cnt
  );
endinterface

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding and load-use stall/bubble.
// Optional stall-cycle counter enabled by defining ID_EXE_STALL_COUNT_EN.
module id_exe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
) (
  input  logic clk,
  input  logic rst,
  id_exe_stage_if.slave bus
);

  logic              r_exWreg;
  logic              r_exM2reg;
  logic              r_exWmem;
  logic              r_exAluimm;
  logic [ALUC_W-1:0] r_exAluc;
  logic [DATA_W-1:0] r_exA;
  logic [DATA_W-1:0] r_exB;
  logic [DATA_W-1:0] r_exImm;
  logic [REG_AW-1:0] r_exDest;

  logic [REG_AW-1:0] w_dest;
  logic [DATA_W-1:0] w_fwdA;
  logic [DATA_W-1:0] w_fwdB;
  logic [DATA_W-1:0] w_memResult;
  logic              w_loadUse;
  logic              w_bubble;

  assign w_dest      = bus.id_regrt ? bus.id_rt : bus.id_rd;
  assign w_memResult = bus.mem_m2reg ? bus.mem_dout : bus.mem_alu;

  // A load still in EX cannot forward yet; it is picked up from MEM after the bubble.
  always_comb begin
    w_fwdA = bus.qa;
    if (bus.id_rs == '0)
      w_fwdA = bus.qa;
    else if (r_exWreg && !r_exM2reg && (r_exDest == bus.id_rs))
      w_fwdA = bus.ex_alu;
    else if (bus.mem_wreg && (bus.mem_dest == bus.id_rs))
      w_fwdA = w_memResult;
  end

  always_comb begin
    w_fwdB = bus.qb;
    if (bus.id_rt == '0)
      w_fwdB = bus.qb;
    else if (r_exWreg && !r_exM2reg && (r_exDest == bus.id_rt))
      w_fwdB = bus.ex_alu;
    else if (bus.mem_wreg && (bus.mem_dest == bus.id_rt))
      w_fwdB = w_memResult;
  end

  assign w_loadUse = r_exWreg && r_exM2reg && (r_exDest != '0) &&
                     ((r_exDest == bus.id_rs) || (bus.id_use_rt && (r_exDest == bus.id_rt)));
  assign w_bubble  = bus.flush || w_loadUse;
  assign bus.stall = w_loadUse && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_exWreg   <= 1'b0;
      r_exM2reg  <= 1'b0;
      r_exWmem   <= 1'b0;
      r_exAluimm <= 1'b0;
      r_exAluc   <= '0;
      r_exA      <= '0;
      r_exB      <= '0;
      r_exImm    <= '0;
      r_exDest   <= '0;
    end else begin
      r_exWreg   <= bus.id_wreg;
      r_exM2reg  <= bus.id_m2reg;
      r_exWmem   <= bus.id_wmem;
      r_exAluimm <= bus.id_aluimm;
      r_exAluc   <= bus.id_aluc;
      r_exA      <= w_fwdA;
      r_exB      <= w_fwdB;
      r_exImm    <= bus.id_imm;
      r_exDest   <= w_dest;
    end
  end

  assign bus.ex_wreg   = r_exWreg;
  assign bus.ex_m2reg  = r_exM2reg;
  assign bus.ex_wmem   = r_exWmem;
  assign bus.ex_aluimm = r_exAluimm;
  assign bus.ex_aluc   = r_exAluc;
  assign bus.ex_a      = r_exA;
  assign bus.ex_b      = r_exB;
  assign bus.ex_imm    = r_exImm;
  assign bus.ex_dest   = r_exDest;

`ifdef ID_EXE_STALL_COUNT_EN
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stallCnt <= '0;
    else if (bus.stall)
      r_stallCnt <= r_stallCnt + 32'd1;
  end

  assign bus.stall_cnt = r_stallCnt;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed self-checking bench for id_exe_stage: reset, forwarding paths, priority,
// load-use stall/bubble, flush override, register 0 and reset during a stall.
module tb_id_exe_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   expCnt;

  id_exe_stage_if #(.DATA_W(32), .REG_AW(5), .ALUC_W(4)) bus ();

  id_exe_stage #(.DATA_W(32), .REG_AW(5), .ALUC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_use_rt = 1'b0; bus.id_regrt = 1'b0; bus.id_wreg = 1'b0;
    bus.id_m2reg = 1'b0; bus.id_wmem = 1'b0; bus.id_aluimm = 1'b0;
    bus.id_aluc = '0; bus.id_imm = '0; bus.qa = '0; bus.qb = '0;
    bus.ex_alu = '0; bus.mem_wreg = 1'b0; bus.mem_m2reg = 1'b0;
    bus.mem_dest = '0; bus.mem_alu = '0; bus.mem_dout = '0; bus.flush = 1'b0;
  endtask

  // Present a decoded instruction: rs, rt, rd, regrt, wreg, m2reg, wmem, use_rt, qa, qb.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic regrt, input logic wreg, input logic m2reg,
                               input logic wmem, input logic useRt,
                               input logic [31:0] a, input logic [31:0] b);
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_regrt = regrt; bus.id_wreg = wreg; bus.id_m2reg = m2reg;
    bus.id_wmem = wmem; bus.id_use_rt = useRt; bus.qa = a; bus.qb = b;
  endtask

  task automatic test_reset();
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3; bus.id_use_rt = 1'b1;
    bus.id_regrt = 1'b1; bus.id_wreg = 1'b1; bus.id_m2reg = 1'b1; bus.id_wmem = 1'b1;
    bus.id_aluimm = 1'b1; bus.id_aluc = 4'hF; bus.id_imm = 32'hFFFF_0001;
    bus.qa = 32'h1111_1111; bus.qb = 32'h2222_2222; bus.ex_alu = 32'h3333_3333;
    bus.mem_wreg = 1'b1; bus.mem_m2reg = 1'b1; bus.mem_dest = 5'd4;
    bus.mem_alu = 32'h4444_4444; bus.mem_dout = 32'h5555_5555; bus.flush = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm} !== 4'b0000) begin
      errors++; $display("[TB] FAIL resetCtrl: got %b expected 0000",
                         {bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm});
    end
    checks++;
    if ({bus.ex_a, bus.ex_b, bus.ex_imm} !== 96'd0) begin
      errors++; $display("[TB] FAIL resetData: got %h %h %h expected zeros", bus.ex_a, bus.ex_b, bus.ex_imm);
    end
    checks++;
    if (bus.ex_dest !== 5'd0 || bus.ex_aluc !== 4'd0) begin
      errors++; $display("[TB] FAIL resetDest: got dest %0d aluc %h expected 0 0", bus.ex_dest, bus.ex_aluc);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL resetStall: got %b expected 0", bus.stall);
    end
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL resetCnt: got %0d expected 0", bus.stall_cnt);
    end
    rst = 1'b0;
    clearInputs();
  endtask

  task automatic test_capture();
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h111, 32'h222);
    bus.id_aluimm = 1'b1; bus.id_aluc = 4'h5; bus.id_imm = 32'h10;
    step();
    checks++;
    if (bus.ex_a !== 32'h111 || bus.ex_b !== 32'h222 || bus.ex_imm !== 32'h10) begin
      errors++; $display("[TB] FAIL captureData: got %h %h %h expected 111 222 10", bus.ex_a, bus.ex_b, bus.ex_imm);
    end
    checks++;
    if (bus.ex_dest !== 5'd3 || bus.ex_aluc !== 4'h5 || bus.ex_wreg !== 1'b1 || bus.ex_aluimm !== 1'b1) begin
      errors++; $display("[TB] FAIL captureCtrl: got dest %0d aluc %h wreg %b aluimm %b expected 3 5 1 1",
                         bus.ex_dest, bus.ex_aluc, bus.ex_wreg, bus.ex_aluimm);
    end
    bus.id_aluimm = 1'b0; bus.id_aluc = '0; bus.id_imm = '0;
  endtask

  task automatic test_ex_forward();
    applyStimulus(5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step();
    applyStimulus(5'd8, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 32'h7);
    bus.ex_alu = 32'h1234;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL exFwdStall: got %b expected 0", bus.stall);
    end
    step();
    checks++;
    if (bus.ex_a !== 32'h0000_1234 || bus.ex_b !== 32'h7) begin
      errors++; $display("[TB] FAIL exFwdA: got %h %h expected 00001234 00000007", bus.ex_a, bus.ex_b);
    end
    bus.ex_alu = '0;
  endtask

  task automatic test_mem_forward();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    bus.mem_wreg = 1'b1; bus.mem_m2reg = 1'b1; bus.mem_dest = 5'd9;
    bus.mem_dout = 32'hCAFE; bus.mem_alu = 32'hBEEF;
    applyStimulus(5'd2, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 32'h99);
    step();
    checks++;
    if (bus.ex_b !== 32'hCAFE || bus.ex_a !== 32'h22 || bus.ex_wmem !== 1'b1) begin
      errors++; $display("[TB] FAIL memLoadFwdB: got b %h a %h wmem %b expected cafe 22 1",
                         bus.ex_b, bus.ex_a, bus.ex_wmem);
    end
    bus.mem_m2reg = 1'b0;
    step();
    checks++;
    if (bus.ex_b !== 32'hBEEF) begin
      errors++; $display("[TB] FAIL memAluFwdB: got %h expected beef", bus.ex_b);
    end
    clearInputs();
  endtask

  task automatic test_priority();
    applyStimulus(5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    bus.mem_wreg = 1'b1; bus.mem_dest = 5'd3; bus.mem_alu = 32'hB; bus.ex_alu = 32'hA;
    applyStimulus(5'd3, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0);
    step();
    checks++;
    if (bus.ex_a !== 32'hA) begin
      errors++; $display("[TB] FAIL priorityA: got %h expected a", bus.ex_a);
    end
    clearInputs();
  endtask

  task automatic test_load_use();
    applyStimulus(5'd0, 5'd10, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    applyStimulus(5'd10, 5'd0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0);
    bus.ex_alu = 32'h777;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL loadUseStall: got %b expected 1", bus.stall);
    end
`ifdef ID_EXE_STALL_COUNT_EN
    expCnt++;
`endif
    step();
    checks++;
    if (bus.ex_wreg !== 1'b0 || bus.ex_a !== 32'h0 || bus.ex_dest !== 5'd0) begin
      errors++; $display("[TB] FAIL loadUseBubble: got wreg %b a %h dest %0d expected 0 0 0",
                         bus.ex_wreg, bus.ex_a, bus.ex_dest);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL loadUseOneCycle: got %b expected 0", bus.stall);
    end
    bus.mem_wreg = 1'b1; bus.mem_m2reg = 1'b1; bus.mem_dest = 5'd10; bus.mem_dout = 32'hD00D;
    step();
    checks++;
    if (bus.ex_a !== 32'hD00D || bus.ex_dest !== 5'd11 || bus.ex_wreg !== 1'b1) begin
      errors++; $display("[TB] FAIL loadUseReplay: got a %h dest %0d wreg %b expected d00d 11 1",
                         bus.ex_a, bus.ex_dest, bus.ex_wreg);
    end
    checks++;
    if (bus.stall_cnt !== expCnt) begin
      errors++; $display("[TB] FAIL stallCount: got %0d expected %0d", bus.stall_cnt, expCnt);
    end
    clearInputs();
  endtask

  task automatic test_rt_and_flush();
    applyStimulus(5'd0, 5'd12, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    applyStimulus(5'd1, 5'd12, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h66, 32'h67);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL rtNoUseStall: got %b expected 0", bus.stall);
    end
    bus.id_use_rt = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL rtUseStall: got %b expected 1", bus.stall);
    end
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flushStall: got %b expected 0", bus.stall);
    end
    step();
    checks++;
    if (bus.ex_wreg !== 1'b0 || bus.ex_a !== 32'h0 || bus.ex_b !== 32'h0 || bus.ex_dest !== 5'd0) begin
      errors++; $display("[TB] FAIL flushBubble: got wreg %b a %h b %h dest %0d expected 0 0 0 0",
                         bus.ex_wreg, bus.ex_a, bus.ex_b, bus.ex_dest);
    end
    clearInputs();
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(5'd0, 5'd10, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    applyStimulus(5'd10, 5'd0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL midStallPre: got %b expected 1", bus.stall);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expCnt = 0;
    checks++;
    if (bus.stall !== 1'b0 || bus.ex_wreg !== 1'b0 || bus.ex_m2reg !== 1'b0) begin
      errors++; $display("[TB] FAIL midStallReset: got stall %b wreg %b m2reg %b expected 0 0 0",
                         bus.stall, bus.ex_wreg, bus.ex_m2reg);
    end
    checks++;
    if (bus.stall_cnt !== expCnt) begin
      errors++; $display("[TB] FAIL midStallCnt: got %0d expected %0d", bus.stall_cnt, expCnt);
    end
    clearInputs();
  endtask

  task automatic test_reg_zero();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h42, 32'h43);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL r0LoadStall: got %b expected 0", bus.stall);
    end
    step();
    checks++;
    if (bus.ex_a !== 32'h42 || bus.ex_b !== 32'h43) begin
      errors++; $display("[TB] FAIL r0Capture: got %h %h expected 42 43", bus.ex_a, bus.ex_b);
    end
    bus.ex_alu = 32'hFFFF; bus.mem_wreg = 1'b1; bus.mem_dest = 5'd0; bus.mem_alu = 32'hEEEE;
    bus.qa = 32'h44;
    step();
    checks++;
    if (bus.ex_a !== 32'h44) begin
      errors++; $display("[TB] FAIL r0NoFwd: got %h expected 44", bus.ex_a);
    end
    clearInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expCnt = 0;
    rst = 1'b0;
    clearInputs();
    $display("[TB] starting id_exe_stage directed tests");
    test_reset();
    test_capture();
    test_ex_forward();
    test_mem_forward();
    test_priority();
    test_load_use();
    test_rt_and_flush();
    test_reset_mid_stall();
    test_reg_zero();
    step();
    checks++;
    if (bus.stall_cnt !== expCnt) begin
      errors++; $display("[TB] FAIL finalCnt: got %0d expected %0d", bus.stall_cnt, expCnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
